// File: rtl/sym_stream_gen.sv
// Interval-driven pseudo-random symbol generator with special-symbol tagging and an
// output FIFO on a valid/ready handshake. Optional macro: SYMGEN_SEED_LOAD_EN (runtime LFSR seed load).
module sym_stream_gen #(
  parameter int          SYM_W = 8,
  parameter int          DEPTH = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                    Clk100M,
  input  logic                    Rst_n,
  input  logic [31:0]             symGenMax,
  input  logic                    genSym,
  input  logic [7:0]              specialEvery,
`ifdef SYMGEN_SEED_LOAD_EN
  input  logic                    seedLoad,
  input  logic [15:0]             seedVal,
`endif
  output logic                    generated,
  output logic                    symValid,
  input  logic                    symReady,
  output logic [SYM_W-1:0]        symData,
  output logic                    symSpecial,
  output logic [$clog2(DEPTH):0]  fillLevel,
  output logic [15:0]             dropCnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = SYM_W + 1;

  // Galois LFSR, right shift, taps folded in when the shifted-out bit is 1
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ 16'hB400;
    end else begin
      r = r;
    end
    return r;
  endfunction

  logic [31:0]   cnt_r;
  logic [15:0]   lfsr_r;
  logic [7:0]    sc_r;
  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          gen_r;
  logic          valid_r;
  logic [EW-1:0] head_r;
  logic [15:0]   drop_r;

  logic [31:0]   interval_s;
  logic          load_s;
  logic [15:0]   seed_fix_s;
  logic          fire_s;
  logic [15:0]   lfsr_nx_s;
  logic          special_s;
  logic [7:0]    sc_nx_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_s;
  logic          drop_s;
  logic [EW-1:0] wdata_s;
  logic [PW-1:0] rd_nx_s;
  logic [CW-1:0] count_nx_s;
  logic [EW-1:0] head_nx_s;

`ifdef SYMGEN_SEED_LOAD_EN
  assign load_s     = seedLoad;
  assign seed_fix_s = (seedVal == 16'h0000) ? SEED : seedVal;
`else
  assign load_s     = 1'b0;
  assign seed_fix_s = SEED;
`endif

  // A load takes priority over a coincident generation event
  assign interval_s = (symGenMax == 32'd0) ? 32'd1 : symGenMax;
  assign fire_s     = genSym && (cnt_r >= (interval_s - 32'd1)) && !load_s;
  assign lfsr_nx_s  = lfsr_step(lfsr_r);

  // Special tagging: every K-th event, K=0 disables
  always_comb begin
    special_s = 1'b0;
    sc_nx_s   = sc_r;
    if (specialEvery == 8'd0) begin
      special_s = 1'b0;
      sc_nx_s   = 8'd0;
    end else if (({1'b0, sc_r} + 9'd1) == {1'b0, specialEvery}) begin
      special_s = 1'b1;
      sc_nx_s   = 8'd0;
    end else begin
      special_s = 1'b0;
      sc_nx_s   = sc_r + 8'd1;
    end
  end

  assign pop_s   = (count_r != '0) && symReady;
  assign full_s  = (count_r == CW'(DEPTH));
  assign wr_s    = fire_s && (!full_s || pop_s);
  assign drop_s  = fire_s && full_s && !pop_s;
  assign wdata_s = {special_s, lfsr_nx_s[SYM_W-1:0]};
  assign rd_nx_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;

  // Next occupancy and next head entry, so the handshake outputs can be registered
  always_comb begin
    count_nx_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_nx_s = count_r + CW'(1);
      2'b01:   count_nx_s = count_r - CW'(1);
      default: count_nx_s = count_r;
    endcase
    if (count_nx_s == '0) begin
      head_nx_s = '0;
    end else if (wr_s && (wr_ptr_r == rd_nx_s)) begin
      head_nx_s = wdata_s;
    end else begin
      head_nx_s = mem_r[rd_nx_s];
    end
  end

  // Interval counter, LFSR and special counter
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_r  <= 32'd0;
      lfsr_r <= SEED;
      sc_r   <= 8'd0;
    end else if (load_s) begin
      cnt_r  <= 32'd0;
      lfsr_r <= seed_fix_s;
      sc_r   <= 8'd0;
    end else begin
      if (!genSym || fire_s) begin
        cnt_r <= 32'd0;
      end else begin
        cnt_r <= cnt_r + 32'd1;
      end
      if (fire_s) begin
        lfsr_r <= lfsr_nx_s;
      end else begin
        lfsr_r <= lfsr_r;
      end
      if (specialEvery == 8'd0) begin
        sc_r <= 8'd0;
      end else if (fire_s) begin
        sc_r <= sc_nx_s;
      end else begin
        sc_r <= sc_r;
      end
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= wdata_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= rd_nx_s;
      count_r  <= count_nx_s;
    end
  end

  // Registered outputs and saturating drop counter
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      gen_r   <= 1'b0;
      valid_r <= 1'b0;
      head_r  <= '0;
      drop_r  <= 16'h0000;
    end else begin
      gen_r   <= fire_s;
      valid_r <= (count_nx_s != '0);
      head_r  <= head_nx_s;
      if (drop_s && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

  assign generated  = gen_r;
  assign symValid   = valid_r;
  assign symData    = head_r[SYM_W-1:0];
  assign symSpecial = head_r[SYM_W];
  assign fillLevel  = count_r;
  assign dropCnt    = drop_r;

endmodule

// File: doc/sym_stream_gen.md
# sym_stream_gen

Parametrised successor to the game-period symbol generator. It issues pseudo-random symbols at a programmable interval while the game period is active, and tags every K-th symbol as special. Symbols are buffered in an internal FIFO and handed downstream over a valid/ready handshake, so the display and scoring logic can stall without losing symbols. A single-cycle `generated` pulse is kept for existing event counters.

## Interface
- `SYM_W`, default 8: symbol width, 1..16.
- `DEPTH`, default 4: FIFO entries, power of 2, ≥2.
- `SEED`, default 16'hACE1: LFSR reset value, must be non-zero.
- `Clk100M`, in, 1: the block's single clock, rising edge.
- `Rst_n`, in, 1: reset, asynchronous and active-low.
- `symGenMax`, in, 32: generation interval in cycles; 0 is treated as 1.
- `genSym`, in, 1: game period active; enables interval counting.
- `specialEvery`, in, 8: K, where every K-th symbol is special; 0 disables special tagging.
- `generated`, out, 1: one-cycle pulse per generation event.
- `symValid`, out, 1: FIFO non-empty; `symData`/`symSpecial` are valid.
- `symReady`, in, 1: downstream pop; a pop occurs when `symValid && symReady`.
- `symData`, out, SYM_W: head symbol (show-ahead).
- `symSpecial`, out, 1: head symbol special flag.
- `fillLevel`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `dropCnt`, out, 16: saturating count of symbols dropped on full.

## Operation
- Interval counter `cnt` (32b):
  - While `genSym` is low, `cnt` is cleared to 0.
  - While `genSym` is high and `cnt >= max(symGenMax,1)-1`, a generation event fires and `cnt` is set to 0. Otherwise `cnt` increments.
  - The `>=` compare means that lowering `symGenMax` mid-count fires on the next edge.
- LFSR: 16-bit Galois, right shift, mask 16'hB400 (applied when the shifted-out LSB is 1).
  - Advances only on a generation event.
  - The symbol is `lfsr_next[SYM_W-1:0]`.
- Special counter `sc` (8b):
  - Increments on each event.
  - When `specialEvery != 0` and `sc+1 == specialEvery`, the symbol is special and `sc` is set to 0.
  - While `specialEvery == 0`, `sc` is held at 0.
- FIFO stores `{special, symbol}` per entry.
  - A push happens on every event.
  - If the FIFO is full and no pop occurs that cycle, the symbol is dropped and `dropCnt` increments, saturating at 16'hFFFF. The LFSR and `sc` still advance.
  - Full plus a simultaneous pop: the push is accepted and occupancy is unchanged.
  - Empty plus an event: there is no same-cycle bypass; the symbol becomes visible at the head after the write edge.
  - A pop while empty is ignored.
- Pointers wrap modulo DEPTH. An extra occupancy bit distinguishes full from empty.

## Timing
- Reset values:
  - All outputs are 0, with `symValid=0` and `fillLevel=0`.
  - `cnt=0`, `sc=0`, `lfsr=SEED`, pointers 0.
- Event latency: with `genSym` high from the first edge after reset release, the first event is registered on edge `max(symGenMax,1)`.
  - `generated`, `symValid`, `symData` and `fillLevel` all update on that same edge.
  - Thereafter events occur every `max(symGenMax,1)` edges.
- `symGenMax` of 0 or 1: an event fires on every edge while `genSym` is high.
- `genSym` deasserted mid-interval: the count restarts from 0 on re-assertion. FIFO contents are kept.
- Pop is registered: the head advances on the edge where `symValid && symReady`.
- `Rst_n` asserted mid-operation:
  - Immediately clears all state, including FIFO contents and `dropCnt`.
  - After release, the LFSR sequence restarts from SEED.

## Configuration
- `SYMGEN_SEED_LOAD_EN`:
  - Defined: adds ports `seedLoad` (in, 1) and `seedVal` (in, 16).
    - `seedLoad` high sets `lfsr<=seedVal`; a value of 0 is replaced by SEED. It also clears `sc` and `cnt`.
    - If load and event coincide, the load wins and no event fires.
  - Undefined: the ports are absent, and the LFSR is set only by reset.

## Test plan
- Reset, `symGenMax=10`, `genSym=1`, `specialEvery=0`, `symReady=1` → first `generated` pulse on edge 10 with `symData=8'h70` (lfsr 16'hE270) and `symSpecial=0`; the next pulse comes on edge 20.
- `symGenMax=1`, `specialEvery=3`, `symReady=1` → an event every edge; `symSpecial` is 1 on events 3, 6, 9, …
- `symReady=0`, `symGenMax=2`, DEPTH=4 → `fillLevel` reaches 4 after 4 events; events 5 and 6 give `dropCnt=2` with `fillLevel` staying at 4. Then `symReady=1` → 4 pops return the first 4 symbols in order.
- FIFO full with `symReady=1` on an event edge → `fillLevel` stays at 4 and `dropCnt` does not change.
- `genSym` dropped at `cnt=5` then raised again (`symGenMax=10`) → the next event comes 10 edges after re-assertion.
- Assert `Rst_n` low mid-stream with 2 entries queued → all outputs go to 0 immediately; after release, the first symbol is again 8'h70. With `SYMGEN_SEED_LOAD_EN`: `seedVal=16'h0001` loaded → first symbol is 8'h00 (lfsr 16'hB400).
